// File: rtl/epl_seq_pkg.sv
// rtl/epl_seq_pkg.sv - shared encodings and constants for the Powerlink cycle sequencer
package epl_seq_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE     = 2'd0;
  localparam seq_state_t ST_WAIT_SOC = 2'd1;
  localparam seq_state_t ST_WAIT_RT  = 2'd2;
  localparam seq_state_t ST_RUN      = 2'd3;

  // Loss window is cycle_len plus cycle_len / 2^LOSS_TOL_SHIFT.
  localparam int LOSS_TOL_SHIFT = 3;
  localparam int DEFAULT_CLK_NS = 20;

endpackage

// File: rtl/epl_local_clock.sv
// rtl/epl_local_clock.sv - 64-bit loadable ns accumulator; load beats increment, clear beats both
module epl_local_clock (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [63:0] value,
  input  logic        inc_en,
  input  logic [63:0] inc,
  output logic [63:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (clr)    acc <= '0;
    else if (load)   acc <= value;
    else if (inc_en) acc <= acc + inc;
  end

endmodule

// File: rtl/epl_cycle_sequencer.sv
// rtl/epl_cycle_sequencer.sv - CN cycle sequencer: SoC-driven timer, local ns clock, sync tick, loss detect
// Optional SoC interval/jitter measurement outputs when EPL_SOC_JITTER_EN is defined.
module epl_cycle_sequencer
  import epl_seq_pkg::*;
#(
  parameter int CLK_NS = DEFAULT_CLK_NS,
  parameter int CYC_W  = 24
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             enable,
  input  logic             soc_det,
  input  logic [63:0]      rt,
  input  logic             rt_valid,
  input  logic [CYC_W-1:0] cfg_cycle_len,
  input  logic [CYC_W-1:0] cfg_sync_off,
  input  logic [3:0]       cfg_loss_lim,
  output logic [63:0]      local_time,
  output logic             local_time_valid,
  output logic             sync_tick,
  output logic [15:0]      cycle_cnt,
  output logic             soc_loss,
`ifdef EPL_SOC_JITTER_EN
  output logic [CYC_W-1:0] meas_len,
  output logic [CYC_W-1:0] jitter_max,
`endif
  output logic [1:0]       state
);

  localparam logic [CYC_W-1:0] ONE = 1;

  logic [CYC_W-1:0] timer;
  logic [CYC_W-1:0] sh_len;
  logic [CYC_W-1:0] sh_off;
  logic [3:0]       sh_lim;
  logic [3:0]       miss_cnt;
  logic [CYC_W:0]   loss_win;
  logic [4:0]       lim_eff;
  logic             in_run;
  logic             loss_hit;
  logic             lim_hit;

  assign in_run    = (state == ST_RUN);
  assign loss_win  = {1'b0, sh_len} + ({1'b0, sh_len} >> LOSS_TOL_SHIFT);
  assign loss_hit  = in_run && !soc_det && ({1'b0, timer} == loss_win);
  assign lim_eff   = (sh_lim == 4'd0) ? 5'd1 : {1'b0, sh_lim};
  assign lim_hit   = ({1'b0, miss_cnt} + 5'd1) >= lim_eff;
  assign sync_tick = in_run && (timer == sh_off) && (sh_off < sh_len);
  assign soc_loss  = loss_hit;

  epl_local_clock u_local_clock (
    .clk    (clk),
    .rst    (rst),
    .clr    (!enable),
    .load   (enable && rt_valid && (state == ST_WAIT_RT || in_run)),
    .value  (rt + 64'(CLK_NS)),
    .inc_en (enable && in_run),
    .inc    (64'(CLK_NS)),
    .acc    (local_time)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      timer            <= '0;
      sh_len           <= '0;
      sh_off           <= '0;
      sh_lim           <= '0;
      miss_cnt         <= '0;
      cycle_cnt        <= '0;
      local_time_valid <= 1'b0;
    end else if (!enable) begin
      state            <= ST_IDLE;
      timer            <= '0;
      miss_cnt         <= '0;
      local_time_valid <= 1'b0;
    end else begin
      timer <= (&timer) ? timer : timer + ONE;
      case (state)
        ST_IDLE: begin
          state <= ST_WAIT_SOC;
          timer <= '0;
        end
        ST_WAIT_SOC: begin
          if (soc_det) begin
            sh_len <= cfg_cycle_len;
            sh_off <= cfg_sync_off;
            sh_lim <= cfg_loss_lim;
            // A zero cycle length cannot be sequenced; keep waiting for a usable config.
            if (cfg_cycle_len != '0) begin
              state <= ST_WAIT_RT;
              timer <= '0;
            end
          end
        end
        ST_WAIT_RT: begin
          if (rt_valid) begin
            state            <= ST_RUN;
            local_time_valid <= 1'b1;
          end else if (timer == sh_len) begin
            state <= ST_WAIT_SOC;
          end
        end
        default: begin
          if (soc_det) begin
            timer     <= '0;
            cycle_cnt <= cycle_cnt + 16'd1;
            miss_cnt  <= '0;
            if (cfg_cycle_len != '0) begin
              sh_len <= cfg_cycle_len;
              sh_off <= cfg_sync_off;
              sh_lim <= cfg_loss_lim;
            end
          end else if (loss_hit) begin
            // Missed SoC: restart as a virtual SoC unless the miss budget is spent.
            timer <= '0;
            if (lim_hit) begin
              state            <= ST_WAIT_SOC;
              local_time_valid <= 1'b0;
              miss_cnt         <= '0;
            end else begin
              miss_cnt  <= miss_cnt + 4'd1;
              cycle_cnt <= cycle_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef EPL_SOC_JITTER_EN
  logic [CYC_W:0] meas_nxt;
  logic [CYC_W:0] jit_abs;

  assign meas_nxt = {1'b0, timer} + {1'b0, ONE};
  assign jit_abs  = (meas_nxt >= {1'b0, sh_len}) ? meas_nxt - {1'b0, sh_len}
                                                 : {1'b0, sh_len} - meas_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_len   <= '0;
      jitter_max <= '0;
    end else if (!enable) begin
      meas_len   <= '0;
      jitter_max <= '0;
    end else if (!in_run) begin
      jitter_max <= '0;
    end else if (soc_det) begin
      meas_len <= meas_nxt[CYC_W-1:0];
      if (jit_abs > {1'b0, jitter_max}) jitter_max <= jit_abs[CYC_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_epl_cycle_sequencer.sv
// tb/tb_epl_cycle_sequencer.sv - directed self-checking bench for epl_cycle_sequencer
module tb_epl_cycle_sequencer;

  logic        rst = 1'b1;
  logic        clk = 1'b0;
  logic        enable = 1'b0;
  logic        soc_det = 1'b0;
  logic [63:0] rt = '0;
  logic        rt_valid = 1'b0;
  logic [23:0] cfg_cycle_len = 24'd50;
  logic [23:0] cfg_sync_off = 24'd10;
  logic [3:0]  cfg_loss_lim = 4'd3;
  logic [63:0] local_time;
  logic        local_time_valid;
  logic        sync_tick;
  logic [15:0] cycle_cnt;
  logic        soc_loss;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int loss_seen = 0;
  int sync_seen = 0;
  logic [63:0] lt_prev;
  logic [15:0] cnt_hold;

  epl_cycle_sequencer #(.CLK_NS(20), .CYC_W(24)) dut (
    .rst              (rst),
    .clk              (clk),
    .enable           (enable),
    .soc_det          (soc_det),
    .rt               (rt),
    .rt_valid         (rt_valid),
    .cfg_cycle_len    (cfg_cycle_len),
    .cfg_sync_off     (cfg_sync_off),
    .cfg_loss_lim     (cfg_loss_lim),
    .local_time       (local_time),
    .local_time_valid (local_time_valid),
    .sync_tick        (sync_tick),
    .cycle_cnt        (cycle_cnt),
    .soc_loss         (soc_loss),
    .state            (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (soc_loss) loss_seen++;
      if (sync_tick) sync_seen++;
    end
  endtask

  task automatic soc_pulse();
    soc_det = 1'b1;
    tick();
    soc_det = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_outs", {59'd0, local_time_valid, sync_tick, soc_loss, 2'd0}, 64'd0);
    chk("rst_time", local_time, 64'd0);
    chk("rst_cnt", 64'(cycle_cnt), 64'd0);
    rst = 1'b0;
    enable = 1'b1;
    tick();
    chk("idle_to_wait_soc", 64'(state), 64'd1);

    // Basic sync: SoC, then RelativeTime 0x1000
    soc_pulse();
    chk("soc_to_wait_rt", 64'(state), 64'd2);
    rt = 64'h1000;
    rt_valid = 1'b1;
    tick();
    rt_valid = 1'b0;
    chk("rt_load_time", local_time, 64'h1014);
    chk("rt_valid_out", 64'(local_time_valid), 64'd1);
    chk("rt_to_run", 64'(state), 64'd3);
    run(8);
    chk("sync_before", 64'(sync_tick), 64'd0);
    tick();
    chk("sync_at_10", 64'(sync_tick), 64'd1);
    chk("time_at_10", local_time, 64'h10C8);
    tick();
    chk("sync_after", 64'(sync_tick), 64'd0);

    // Steady state: SoCs at +50, +100, +150, +200
    run(38);
    soc_pulse();
    loss_seen = 0;
    sync_seen = 0;
    lt_prev = '0;
    for (int c = 0; c < 3; c++) begin
      lt_prev = local_time;
      run(49);
      soc_pulse();
    end
    chk("steady_cnt", 64'(cycle_cnt), 64'd4);
    chk("steady_loss", 64'(loss_seen), 64'd0);
    chk("steady_sync", 64'(sync_seen), 64'd3);
    chk("steady_time", local_time, 64'h1FA0);
    chk("steady_delta", local_time - lt_prev, 64'd1000);

    // Boundary: SoC exactly while timer sits at 56
    loss_seen = 0;
    run(55);
    tick();
    soc_det = 1'b1;
    #1;
    chk("boundary_no_loss", 64'(soc_loss), 64'd0);
    tick();
    soc_det = 1'b0;
    chk("boundary_loss_cnt", 64'(loss_seen), 64'd0);
    chk("boundary_cnt", 64'(cycle_cnt), 64'd5);

    // Loss: three consecutive misses, 57 clocks apart
    run(55);
    chk("loss1_quiet", 64'(loss_seen), 64'd0);
    tick();
    chk("loss1_pulse", 64'(soc_loss), 64'd1);
    run(56);
    chk("loss2_quiet", 64'(loss_seen), 64'd0);
    tick();
    chk("loss2_pulse", 64'(soc_loss), 64'd1);
    chk("loss2_state", 64'(state), 64'd3);
    chk("loss2_cnt", 64'(cycle_cnt), 64'd6);
    run(56);
    chk("loss3_quiet", 64'(loss_seen), 64'd0);
    tick();
    chk("loss3_pulse", 64'(soc_loss), 64'd1);
    tick();
    chk("desync_state", 64'(state), 64'd1);
    chk("desync_valid", 64'(local_time_valid), 64'd0);

    // Missing rt: WAIT_RT times out after cycle_len without a loss pulse
    loss_seen = 0;
    soc_pulse();
    chk("nort_wait_rt", 64'(state), 64'd2);
    run(50);
    chk("nort_still", 64'(state), 64'd2);
    run(1);
    chk("nort_back", 64'(state), 64'd1);
    chk("nort_no_loss", 64'(loss_seen), 64'd0);

    // Zero cycle length: SoC ignored
    cfg_cycle_len = 24'd0;
    soc_pulse();
    chk("zero_len_ignored", 64'(state), 64'd1);
    cfg_cycle_len = 24'd50;

    // Enable drop in RUN
    soc_pulse();
    rt = 64'h2000;
    rt_valid = 1'b1;
    tick();
    rt_valid = 1'b0;
    chk("resync_time", local_time, 64'h2014);
    cnt_hold = cycle_cnt;
    enable = 1'b0;
    tick();
    chk("dis_state", 64'(state), 64'd0);
    chk("dis_time", local_time, 64'd0);
    chk("dis_outs", {61'd0, local_time_valid, sync_tick, soc_loss}, 64'd0);
    chk("dis_cnt_hold", 64'(cycle_cnt), 64'(cnt_hold));

    // Async reset in WAIT_RT
    enable = 1'b1;
    tick();
    soc_pulse();
    chk("pre_rst_state", 64'(state), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_cnt", 64'(cycle_cnt), 64'd0);
    chk("arst_time", local_time, 64'd0);
    chk("arst_outs", {61'd0, local_time_valid, sync_tick, soc_loss}, 64'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
